// File: rtl/lsu_mem_port_pkg.sv
// Shared mask codes, FSM state encoding and the request legality check for
// the load/store memory port. The decode stage uses the same mask codes.
package lsu_mem_port_pkg;

  localparam logic [7:0] WBYTE = 8'h01;
  localparam logic [7:0] WHALF = 8'h03;
  localparam logic [7:0] WWORD = 8'h0F;

  localparam logic [2:0] LOADW  = 3'd0;
  localparam logic [2:0] LOADH  = 3'd1;
  localparam logic [2:0] LOADHU = 3'd2;
  localparam logic [2:0] LOADB  = 3'd3;
  localparam logic [2:0] LOADBU = 3'd4;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_RREQ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Exactly one access kind, a known mask code, and natural alignment.
  function automatic logic req_legal(input logic       ren,
                                     input logic       wen,
                                     input logic [7:0] wm,
                                     input logic [2:0] rm,
                                     input logic [1:0] off);
    logic ok;
    ok = ren ^ wen;
    if (wen) begin
      case (wm)
        WBYTE:   ;
        WHALF:   if (off[0]) ok = 1'b0;
        WWORD:   if (off != 2'b00) ok = 1'b0;
        default: ok = 1'b0;
      endcase
    end else begin
      case (rm)
        LOADW:          if (off != 2'b00) ok = 1'b0;
        LOADH, LOADHU:  if (off[0]) ok = 1'b0;
        LOADB, LOADBU:  ;
        default:        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Byte-lane steering: store data shift and strobe, load field extract and
// sign/zero extension. Purely combinational.
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [7:0]  wmask,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  input  logic [2:0]  rmask,
  input  logic [31:0] rword,
  output logic [31:0] rdata_ext
);

  logic [31:0] field;

  always_comb begin
    wdata_lane = wdata << {off, 3'b000};
    case (wmask)
      WBYTE:   wstrb = 4'b0001 << off;
      WHALF:   wstrb = 4'b0011 << off;
      WWORD:   wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    field = rword >> {off, 3'b000};
    case (rmask)
      LOADB:   rdata_ext = {{24{field[7]}}, field[7:0]};
      LOADBU:  rdata_ext = {24'h0, field[7:0]};
      LOADH:   rdata_ext = {{16{field[15]}}, field[15:0]};
      LOADHU:  rdata_ext = {16'h0, field[15:0]};
      default: rdata_ext = field;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one transaction at a time over a valid/ready
// word bus, with a bounded wait and a single-cycle response.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [7:0]  wmask,
  input  logic [2:0]  rmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  rmask_q, rmask_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  lsu_lane_align u_align (
    .off        (addr_q[1:0]),
    .wmask      (wmask_q),
    .wdata      (wdata_q),
    .wstrb      (lane_wstrb),
    .wdata_lane (lane_wdata),
    .rmask      (rmask_q),
    .rword      (bus_rdata),
    .rdata_ext  (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rmask_d = rmask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = addr;
          wdata_d = wdata;
          wmask_d = wmask;
          rmask_d = rmask;
          we_d    = mem_wen;
          cnt_d   = 8'd0;
          if (!req_legal(mem_ren, mem_wen, wmask, rmask, addr[1:0]))
            state_d = ST_ERR;
          else if (mem_wen)
            state_d = ST_WREQ;
          else
            state_d = ST_RREQ;
        end
      end
      ST_WREQ, ST_RREQ: begin
        if (bus_ready) begin
          state_d = (state_q == ST_WREQ) ? ST_RESP : ST_RWAIT;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RWAIT: begin
        // Read data only counts once the address phase has completed.
        if (bus_rvalid) begin
          state_d = ST_RESP;
          rdata_d = lane_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR || (state_d == ST_RESP && state_q == ST_WREQ))
      rdata_d = 32'h0;
  end

  // Ready is a flop so it stays low through reset and rises one cycle later.
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 8'h0;
      rmask_q <= 3'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rmask_q <= rmask_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign bus_valid  = (state_q == ST_WREQ) || (state_q == ST_RREQ);
  assign bus_we     = bus_valid && we_q;
  assign bus_addr   = {addr_q[31:2], 2'b00};
  assign bus_wstrb  = bus_we ? lane_wstrb : 4'b0000;
  assign bus_wdata  = bus_we ? lane_wdata : 32'h0;
  assign resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign err        = (state_q == ST_ERR);
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares each resp_valid pulse.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  wmask;
  logic [2:0]  rmask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_mem_port #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .wmask      (wmask),
    .rmask      (rmask),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   resp_cnt = 0;
  logic auto_rsp = 1'b1;
  logic force_rv = 1'b0;
  logic hs_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) acc_cyc = cyc;
    if (resp_valid) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got resp_valid err=%0b rdata=%h expected no response", err, rdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_err", 32'(err), 32'(mon_e.err));
        check("resp_rdata", rdata, mon_e.rdata);
        check("resp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
        $display("resp #%0d: err=%0b rdata=%h latency=%0d", resp_cnt, err, rdata, cyc - acc_cyc);
      end
    end
  end

  // Bus model: read data arrives the cycle after an accepted read address phase.
  initial begin
    bus_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      hs_n = (auto_rsp && bus_valid && bus_ready && !bus_we) || force_rv;
      @(posedge clk);
      #1 bus_rvalid = hs_n;
    end
  end

  task automatic issue(input logic ren, input logic wen, input logic [7:0] wm,
                       input logic [2:0] rm, input logic [31:0] a, input logic [31:0] wd,
                       input logic push, input logic e_err, input logic [31:0] e_rd, input int lat);
    exp_t e;
    bit   acc;
    if (push) begin
      e.err = e_err; e.rdata = e_rd; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1; mem_ren = ren; mem_wen = wen;
    wmask = wm; rmask = rm; addr = a; wdata = wd;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
    end
    if (!acc) begin
      total++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 40 cycles");
      if (push) void'(sb_q.pop_back());
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    $display("req: ren=%0b wen=%0b wmask=%h rmask=%0d addr=%h wdata=%h", ren, wen, wm, rm, a, wd);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  int vcount;
  int rc_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    wmask = 8'h0; rmask = 3'd0; addr = 32'h0; wdata = 32'h0;
    bus_ready = 1'b1; bus_rdata = 32'h1280_3456;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // sw aligned
    issue(1'b0, 1'b1, 8'h0F, 3'd0, 32'h8000_0104, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 2);
    @(negedge clk);
    check("sw_bus_valid", 32'(bus_valid), 32'd1);
    check("sw_bus_we", 32'(bus_we), 32'd1);
    check("sw_bus_addr", bus_addr, 32'h8000_0104);
    check("sw_bus_wstrb", 32'(bus_wstrb), 32'hF);
    check("sw_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_bus_valid_drop", 32'(bus_valid), 32'd0);
    drain();

    // sb top lane
    issue(1'b0, 1'b1, 8'h01, 3'd0, 32'h8000_0103, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 2);
    @(negedge clk);
    check("sb_bus_addr", bus_addr, 32'h8000_0100);
    check("sb_bus_wstrb", 32'(bus_wstrb), 32'h8);
    check("sb_bus_wdata", bus_wdata, 32'hA500_0000);
    drain();

    // sh upper half
    issue(1'b0, 1'b1, 8'h03, 3'd0, 32'h8000_0106, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0, 2);
    @(negedge clk);
    check("sh_bus_wstrb", 32'(bus_wstrb), 32'hC);
    check("sh_bus_wdata", bus_wdata, 32'hBEEF_0000);
    drain();

    // Loads from word 0x1280_3456
    issue(1'b1, 1'b0, 8'h00, 3'd3, 32'h8000_0102, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 3);
    @(negedge clk);
    check("lb_bus_valid", 32'(bus_valid), 32'd1);
    check("lb_bus_we", 32'(bus_we), 32'd0);
    check("lb_bus_addr", bus_addr, 32'h8000_0100);
    drain();
    issue(1'b1, 1'b0, 8'h00, 3'd4, 32'h8000_0102, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 3);
    drain();
    @(negedge clk);
    check("rdata_hold", rdata, 32'h0000_0080);
    issue(1'b1, 1'b0, 8'h00, 3'd1, 32'h8000_0102, 32'h0, 1'b1, 1'b0, 32'h0000_1280, 3);
    drain();
    bus_rdata = 32'h8000_F000;
    issue(1'b1, 1'b0, 8'h00, 3'd1, 32'h8000_0100, 32'h0, 1'b1, 1'b0, 32'hFFFF_F000, 3);
    drain();
    issue(1'b1, 1'b0, 8'h00, 3'd2, 32'h8000_0100, 32'h0, 1'b1, 1'b0, 32'h0000_F000, 3);
    drain();
    issue(1'b1, 1'b0, 8'h00, 3'd0, 32'h8000_0100, 32'h0, 1'b1, 1'b0, 32'h8000_F000, 3);
    drain();
    // Store response clears rdata
    issue(1'b0, 1'b1, 8'h01, 3'd0, 32'h8000_0000, 32'h0000_0011, 1'b1, 1'b0, 32'h0, 2);
    drain();

    // Illegal requests
    issue(1'b1, 1'b0, 8'h00, 3'd1, 32'h8000_0101, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    @(negedge clk);
    check("lh_mis_bus_valid", 32'(bus_valid), 32'd0);
    drain();
    issue(1'b0, 1'b1, 8'h0F, 3'd0, 32'h8000_0102, 32'h1, 1'b1, 1'b1, 32'h0, 1);
    drain();
    issue(1'b1, 1'b1, 8'h0F, 3'd0, 32'h8000_0100, 32'h1, 1'b1, 1'b1, 32'h0, 1);
    drain();
    issue(1'b0, 1'b1, 8'h07, 3'd0, 32'h8000_0100, 32'h1, 1'b1, 1'b1, 32'h0, 1);
    drain();
    issue(1'b1, 1'b0, 8'h00, 3'd5, 32'h8000_0100, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    drain();

    // Address-phase timeout, then a stray rvalid
    bus_ready = 1'b0;
    issue(1'b1, 1'b0, 8'h00, 3'd0, 32'h8000_0200, 32'h0, 1'b1, 1'b1, 32'h0, 5);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_valid) vcount++;
    end
    check("timeout_bus_valid_cycles", 32'(vcount), 32'd4);
    drain();
    rc_before = resp_cnt;
    @(posedge clk);
    #1 force_rv = 1'b1;
    @(negedge clk);
    #1 force_rv = 1'b0;
    repeat (4) @(negedge clk);
    check("late_rvalid_no_resp", 32'(resp_cnt), 32'(rc_before));
    check("late_rvalid_ready", 32'(req_ready), 32'd1);
    bus_ready = 1'b1;

    // Reset while waiting for read data
    auto_rsp = 1'b0;
    rc_before = resp_cnt;
    issue(1'b1, 1'b0, 8'h00, 3'd0, 32'h8000_0300, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    check("rwait_bus_valid", 32'(bus_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_bus_valid", 32'(bus_valid), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_no_resp", 32'(resp_cnt), 32'(rc_before));
    auto_rsp = 1'b1;
    issue(1'b0, 1'b1, 8'h0F, 3'd0, 32'h8000_0010, 32'h1122_3344, 1'b1, 1'b0, 32'h0, 2);
    @(negedge clk);
    check("post_rst_sw_wdata", bus_wdata, 32'h1122_3344);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "global timeout");
  end

endmodule
